// File: rtl/cmp_pkg.sv
// Shared types and constants for the nibble-serial comparator controllers.
package cmp_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cmp_state_t;

  typedef struct packed {
    logic less;
    logic greater;
  } cmp_res_t;

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Operand and result handshakes of the sequential comparator.
interface cmp_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             less;
  logic             greater;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, less, greater
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, less, greater
  );
endinterface

// File: rtl/cmp4.sv
// 4-bit unsigned magnitude comparator slice.
module cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       less,
  output logic       greater
);
  assign less    = (a < b);
  assign greater = (a > b);
endmodule

// File: rtl/cmp_seq_ctrl.sv
// Compares two WIDTH-bit unsigned operands one nibble per cycle, MSB first,
// through a single shared cmp4, stopping at the first differing nibble.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  cmp_seq_ctrl_if.slave bus,
  output logic          busy
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_width_check
      $error("cmp_seq_ctrl: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  cmp_state_t                     state, state_next;
  logic [IDX_W-1:0]               idx;
  logic [NSLICE-1:0][SLICE_W-1:0] a_reg, b_reg;
  cmp_res_t                       res, slice_res;
  logic                           load, step, latch;

  cmp4 u_slice (
    .a       (a_reg[idx]),
    .b       (b_reg[idx]),
    .less    (slice_res.less),
    .greater (slice_res.greater)
  );

  // At idx==0 an equal slice reports 00, so latching slice_res covers equality.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (slice_res.less || slice_res.greater || idx == '0) begin
          latch      = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      res   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        idx   <= IDX_W'(NSLICE - 1);
      end
      if (step)  idx <= idx - IDX_W'(1);
      if (latch) res <= slice_res;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.less      = res.less;
  assign bus.greater   = res.greater;
  assign busy          = (state != IDLE);

endmodule
